// File: rtl/mc_maindec.sv
// mc_maindec: multicycle control FSM (fetch/decode/exec/mem/wb) driving datapath enables, with mem_ready handshake and optional timeout
module mc_maindec #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       imm_zext,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, IEXEC = 4'd9, IWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t state, state_n;
  logic [5:0] op_q;
  logic [TO_W-1:0] to_cnt;
  logic waiting, timeout;
  assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign mem_err = timeout;
  assign state_o = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      op_q   <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_n;
      op_q   <= (state == DECODE) ? op : op_q;
      to_cnt <= (MEM_TIMEOUT > 0 && waiting && !timeout) ? to_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_n    = FETCH;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    imm_zext   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_n = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        casez (op)
          6'b000000:           state_n = EXEC;
          6'b100011, 6'b101011: state_n = MEMADR;
          6'b000100:           state_n = BRANCH;
          6'b000010:           state_n = JUMP;
          6'b001???:           state_n = IEXEC;
          default:             illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = (op_q == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_n = mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_n    = (mem_ready || timeout) ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_n = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        instr_done = 1'b1;
      end
      IEXEC: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluop    = 2'b11;
        imm_zext = (op_q == 6'b001100 || op_q == 6'b001101 || op_q == 6'b001110);
        state_n  = IWB;
      end
      IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: randomized scoreboard bench for mc_maindec with MEM_TIMEOUT=0 and MEM_TIMEOUT=4 instances
module tb_mc_maindec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0;
  logic [5:0] op = '0;
  always #5 clk = ~clk;
  logic mem_req [2], iord [2], memwrite [2], irwrite [2], pcwrite [2], branch [2];
  logic alusrca [2], imm_zext [2], regdst [2], memtoreg [2], regwrite [2];
  logic instr_done [2], illegal_op [2], mem_err [2];
  logic [1:0] pcsrc [2], alusrcb [2], aluop [2];
  logic [3:0] state_o [2];
  logic [23:0] got [2];
  for (genvar g = 0; g < 2; g++) begin : d
    mc_maindec #(.MEM_TIMEOUT(4 * g), .TO_W(8)) u (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req[g]), .iord(iord[g]), .memwrite(memwrite[g]), .irwrite(irwrite[g]),
      .pcwrite(pcwrite[g]), .branch(branch[g]), .pcsrc(pcsrc[g]), .alusrca(alusrca[g]),
      .alusrcb(alusrcb[g]), .aluop(aluop[g]), .imm_zext(imm_zext[g]), .regdst(regdst[g]),
      .memtoreg(memtoreg[g]), .regwrite(regwrite[g]), .instr_done(instr_done[g]),
      .illegal_op(illegal_op[g]), .mem_err(mem_err[g]), .state_o(state_o[g])
    );
    assign got[g] = {mem_req[g], iord[g], memwrite[g], irwrite[g], pcwrite[g], branch[g],
                     pcsrc[g], alusrca[g], alusrcb[g], aluop[g], imm_zext[g], regdst[g],
                     memtoreg[g], regwrite[g], instr_done[g], illegal_op[g], mem_err[g], state_o[g]};
  end
  // Reference model: each DUT instance tracks its current state plus the list of
  // states still to visit for the decoded instruction class.
  int cur [2];
  logic [5:0] opq [2];
  int waited [2];
  int path [2][$];
  typedef struct packed { logic [23:0] e0; logic [23:0] e1; } exp_t;
  exp_t sb [$];
  int vecs = 0;
  int errs = 0;
  function automatic logic [23:0] expect_ctl(int s, logic [5:0] oq, logic rdy, logic err, logic ill);
    logic mr, io, mw, iw, pw, br, as, iz, rd, mt, rw, dn;
    logic [1:0] ps, bs, ao;
    {mr, io, mw, iw, pw, br, as, iz, rd, mt, rw, dn} = '0;
    {ps, bs, ao} = '0;
    case (s)
      0: begin mr = 1; bs = 2'b01; iw = rdy; pw = rdy; end
      1: bs = 2'b11;
      2: begin as = 1; bs = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin mt = 1; rw = 1; dn = 1; end
      5: begin mr = 1; io = 1; mw = 1; dn = rdy; end
      6: begin as = 1; ao = 2'b10; end
      7: begin rd = 1; rw = 1; dn = 1; end
      8: begin as = 1; ao = 2'b01; br = 1; ps = 2'b01; dn = 1; end
      9: begin as = 1; bs = 2'b10; ao = 2'b11; iz = (oq inside {6'h0c, 6'h0d, 6'h0e}); end
      10: begin rw = 1; dn = 1; end
      11: begin pw = 1; ps = 2'b10; dn = 1; end
      default: ;
    endcase
    return {mr, io, mw, iw, pw, br, ps, as, bs, ao, iz, rd, mt, rw, dn, ill, err, 4'(s)};
  endfunction
  task automatic step(input int di, input logic r, input logic [5:0] o, input logic rdy, output logic [23:0] e);
    int s = cur[di];
    int t = 4 * di;
    logic ws, err, ill;
    ws = (s == 0 || s == 3 || s == 5) && !rdy;
    err = (t > 0) && ws && (waited[di] == t - 1);
    ill = 1'b0;
    if (s == 1) begin
      path[di].delete();
      if (o == 6'b100011) path[di] = '{2, 3, 4};
      else if (o == 6'b101011) path[di] = '{2, 5};
      else if (o == 6'b000000) path[di] = '{6, 7};
      else if (o == 6'b000100) path[di] = '{8};
      else if (o == 6'b000010) path[di] = '{11};
      else if (o[5:3] == 3'b001) path[di] = '{9, 10};
      else ill = 1'b1;
    end
    e = expect_ctl(s, opq[di], rdy, err, ill);
    if (r) begin
      cur[di] = 0; opq[di] = '0; waited[di] = 0; path[di].delete();
    end else if (ws) begin
      if (err) begin cur[di] = 0; waited[di] = 0; path[di].delete(); end
      else waited[di]++;
    end else begin
      waited[di] = 0;
      if (s == 1) opq[di] = o;
      if (s == 0) cur[di] = 1;
      else cur[di] = (path[di].size() > 0) ? path[di].pop_front() : 0;
    end
  endtask
  function automatic logic [5:0] pick_op();
    logic [5:0] v;
    case ($urandom_range(0, 9))
      0: v = 6'b100011;
      1: v = 6'b101011;
      2: v = 6'b000000;
      3: v = 6'b000100;
      4: v = 6'b000010;
      5, 6: v = {3'b001, 3'($urandom_range(0, 7))};
      7, 8: v = 6'($urandom);
      default: v = 6'b111111;
    endcase
    return v;
  endfunction
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      vecs++;
      if (got[0] !== x.e0) begin
        errs++;
        $display("FAIL ctl_t0 t=%0t state=%0d got=%h exp=%h", $time, state_o[0], got[0], x.e0);
      end
      vecs++;
      if (got[1] !== x.e1) begin
        errs++;
        $display("FAIL ctl_t4 t=%0t state=%0d got=%h exp=%h", $time, state_o[1], got[1], x.e1);
      end
    end
  end
  initial begin
    exp_t x;
    for (int k = 0; k < 2; k++) begin cur[k] = 0; opq[k] = '0; waited[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 250) % 3;
      rst = (i == 0) || ($urandom_range(0, 59) == 0);
      op = pick_op();
      mem_ready = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 4);
      step(0, rst, op, mem_ready, x.e0);
      step(1, rst, op, mem_ready, x.e1);
      sb.push_back(x);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errs++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
